fetch_queue: RTL and testbench

- Instruction fetch stage directly upstream of decode and immediate generation.
- Owns the PC and issues word requests to a fixed 1-cycle-latency instruction memory.
- Buffers returned words with their PC in a small FIFO; presents the head to decode, whose `if_inst` feeds the immediate generator's instruction input.
- Accepts branch/jump redirects from execute and discards stale in-flight data.

---
 rtl/fetch_queue_pkg.sv | 22 ++
 rtl/fetch_queue_fifo.sv | 82 ++++++++
 rtl/fetch_queue.sv | 152 +++++++++++++++
 tb/tb_fetch_queue.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared constants and types for the fetch stage
// Contents: NOP encoding, PC step, opcode field range, fetch buffer entry type.

package fetch_queue_pkg;

  // Canonical NOP (addi x0, x0, 0) shown to decode whenever nothing is valid.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Byte distance between sequential instruction words.
  localparam logic [31:0] PC_STEP = 32'd4;

  // Opcode field of an instruction word, as sliced by decode.
  localparam int IR_OPCODE_HI = 6;
  localparam int IR_OPCODE_LO = 0;

  // One buffered fetch: the word together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// rtl/fetch_queue_fifo.sv - small power-of-two FIFO holding fetched {pc, inst} entries
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   push, push_data   write an entry at the tail
//   pop               retire the head entry (ignored when empty)
//   flush             discard all entries; overrides push and pop in the same cycle
//   head_data         head entry, read straight from storage
//   count             number of valid entries (0..DEPTH)

module fetch_queue_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_COUNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   COUNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;

  assign head_data = mem[rd_ptr];

  // Storage carries no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // The request credit upstream must make overflow impossible.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(do_push && full && !do_pop));
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage: PC, imem request credit, fetch buffer
// Optional feature macro: FETCH_MISALIGN_EXC_EN (misaligned redirect halts fetch and
// presents a single flagged NOP entry; adds port if_misaligned).
// Ports:
//   clk, rst                     rising-edge clock, asynchronous active-high reset
//   imem_req, imem_addr          word request to 1-cycle-latency instruction memory
//   imem_rdata                   returned word, valid the cycle after imem_req
//   redirect_valid, redirect_pc  control-flow redirect from execute
//   id_ready                     decode takes the head entry this cycle
//   if_valid, if_inst, if_pc     head entry toward decode (NOP / 0 when empty)
//   if_pc_plus4                  if_pc + 4, wrapping

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
`ifdef FETCH_MISALIGN_EXC_EN
  ,
  output logic        if_misaligned
`endif
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   pc_q;
  logic [31:0]   pend_pc_q;
  logic          pend_q;
  logic          drop_q;

  logic [CW-1:0] fifo_count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          fifo_valid;
  logic          fire_pop;
  logic          fire_push;
  logic [CW:0]   credit_used;
  logic [31:0]   redirect_target;
  logic          halted;

  assign fifo_valid = (fifo_count != '0);
  assign fire_pop   = fifo_valid && id_ready && !redirect_valid;
  assign fire_push  = pend_q && !drop_q && !redirect_valid;
  assign push_entry = {pend_pc_q, imem_rdata};

  // Entries held plus the response in flight, less the head leaving this cycle.
  // Counting the departing head lets a 2-deep buffer sustain one word per cycle
  // while still never issuing a request whose data could find the buffer full.
  assign credit_used = {1'b0, fifo_count}
                     + {{CW{1'b0}}, pend_q}
                     - {{CW{1'b0}}, fire_pop};

  assign imem_req  = !rst && !redirect_valid && !halted && (credit_used < DEPTH_W);
  assign imem_addr = pc_q;

`ifdef FETCH_MISALIGN_EXC_EN
  logic        halt_q;
  logic        halt_valid_q;
  logic [31:0] halt_pc_q;
  logic        misaligned;

  assign misaligned      = (redirect_pc[1:0] != 2'b00);
  assign redirect_target = redirect_pc;
  assign halted          = halt_q;

  // A misaligned target parks fetch; its lone flagged entry can be consumed,
  // but only another redirect (or reset) restarts fetching.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_q       <= 1'b0;
      halt_valid_q <= 1'b0;
      halt_pc_q    <= '0;
    end else if (redirect_valid) begin
      halt_q       <= misaligned;
      halt_valid_q <= misaligned;
      halt_pc_q    <= redirect_pc;
    end else if (halt_q && halt_valid_q && id_ready) begin
      halt_valid_q <= 1'b0;
    end
  end
`else
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign halted          = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      pend_q <= imem_req;
      // A response already in flight at a redirect belongs to the old path.
      drop_q <= redirect_valid && pend_q;
      if (imem_req) begin
        pend_pc_q <= pc_q;
      end
      if (redirect_valid) begin
        pc_q <= redirect_target;
      end else if (imem_req) begin
        pc_q <= pc_q + PC_STEP;
      end
    end
  end

  fetch_queue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fire_push),
    .push_data (push_entry),
    .pop       (fire_pop),
    .flush     (redirect_valid),
    .head_data (head),
    .count     (fifo_count)
  );

  always_comb begin
    if_valid = fifo_valid;
    if_inst  = fifo_valid ? head.inst : NOP_INST;
    if_pc    = fifo_valid ? head.pc   : '0;
`ifdef FETCH_MISALIGN_EXC_EN
    if_misaligned = 1'b0;
    if (halt_q) begin
      if_valid      = halt_valid_q;
      if_inst       = NOP_INST;
      if_pc         = halt_valid_q ? halt_pc_q : '0;
      if_misaligned = halt_valid_q;
    end
`endif
  end

  assign if_pc_plus4 = if_pc + PC_STEP;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue with a queue-based reference model

module tb_fetch_queue;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'hBAD0_BAD0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
`ifdef FETCH_MISALIGN_EXC_EN
  logic        if_misaligned;
`endif

  always #5 clk = ~clk;

  fetch_queue #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
`ifdef FETCH_MISALIGN_EXC_EN
    .if_misaligned  (if_misaligned),
`endif
    .if_pc_plus4    (if_pc_plus4)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h6B00_0000;
  endfunction

  // Instruction memory: one-cycle latency, garbage when not requested.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? word_of(imem_addr) : 32'hBAD0_BAD0;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: program order as a queue of PCs.
  logic [31:0] m_pc;
  bit          m_pend;
  bit          m_drop;
  logic [31:0] m_pend_pc;
  logic [31:0] mq[$];
  bit          m_halted;
  bit          m_hv;
  logic [31:0] m_hpc;

  logic        obs_req;
  logic [31:0] obs_addr;
  logic        obs_valid;
  logic [31:0] obs_pc;
  logic [31:0] obs_pc4;
  logic [31:0] obs_inst;

  task automatic model_reset();
    m_pc = RESET_PC; m_pend = 0; m_drop = 0; m_pend_pc = '0;
    mq.delete(); m_halted = 0; m_hv = 0; m_hpc = '0;
  endtask

  task automatic cycle(input bit rdy, input bit redir, input logic [31:0] tgt);
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    bit          pop;
    bit          e_req;
    bit          mis;
    int          in_flight;
    @(negedge clk);
    rst = 1'b0; id_ready = rdy; redirect_valid = redir; redirect_pc = tgt;
    #1;
    e_valid = m_halted ? m_hv : (mq.size() != 0);
    e_pc    = m_halted ? (m_hv ? m_hpc : 32'h0) : (mq.size() != 0 ? mq[0] : 32'h0);
    e_inst  = (m_halted || mq.size() == 0) ? NOP : word_of(mq[0]);
    pop     = e_valid && rdy && !redir;
    // Words owed to decode after this cycle's departure must stay within the buffer.
    in_flight = mq.size() + int'(m_pend) - ((pop && !m_halted) ? 1 : 0);
    e_req   = !redir && !m_halted && (in_flight < DEPTH);

    obs_req = imem_req; obs_addr = imem_addr; obs_valid = if_valid;
    obs_pc = if_pc; obs_pc4 = if_pc_plus4; obs_inst = if_inst;
    check("if_valid", if_valid, e_valid);
    check("if_pc", if_pc, e_pc);
    check("if_inst", if_inst, e_inst);
    check("if_pc_plus4", if_pc_plus4, e_pc + 32'd4);
    check("imem_req", imem_req, e_req);
    check("imem_addr", imem_addr, m_pc);
`ifdef FETCH_MISALIGN_EXC_EN
    check("if_misaligned", if_misaligned, m_halted && m_hv);
`endif

    if (redir) begin
      mq.delete();
      m_drop = m_pend;
      m_pend = 0;
`ifdef FETCH_MISALIGN_EXC_EN
      mis = (tgt[1:0] != 2'b00);
      m_pc = tgt;
`else
      mis = 0;
      m_pc = {tgt[31:2], 2'b00};
`endif
      m_halted = mis; m_hv = mis; m_hpc = tgt;
    end else begin
      if (pop && m_halted) m_hv = 0;
      else if (pop) void'(mq.pop_front());
      if (m_pend && !m_drop) mq.push_back(m_pend_pc);
      m_drop = 0;
      m_pend = e_req;
      if (e_req) begin
        m_pend_pc = m_pc;
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0;
    #1;
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", if_valid, 1'b0);
    check("rst_inst", if_inst, NOP);
    check("rst_pc", if_pc, 32'h0);
    check("rst_addr", imem_addr, RESET_PC);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_hold_valid", if_valid, 1'b0);
  endtask

  initial begin
    model_reset();
    do_reset();

    // Streaming from reset: first word two cycles after first request, then one per cycle.
    for (int k = 0; k < 10; k++) begin
      cycle(1, 0, 32'h0);
      if (k == 0) begin
        check("first_req", obs_req, 1'b1);
        check("first_addr", obs_addr, 32'h0);
      end
      if (k == 1) check("lat_not_yet", obs_valid, 1'b0);
      if (k >= 2) begin
        check("thru_valid", obs_valid, 1'b1);
        check("thru_pc", obs_pc, 32'(4 * (k - 2)));
      end
    end

    // Stall: buffer fills to DEPTH, requests stop, then drains in order.
    for (int k = 0; k < 5; k++) cycle(0, 0, 32'h0);
    check("stall_req", obs_req, 1'b0);
    check("stall_head", obs_pc, 32'h20);
    cycle(1, 0, 32'h0);
    check("drain0", obs_pc, 32'h20);
    cycle(1, 0, 32'h0);
    check("drain1", obs_pc, 32'h24);

    // Redirect while a response is in flight.
    for (int k = 0; k < 3; k++) cycle(1, 0, 32'h0);
    check("pre_redir_pend", m_pend, 1'b1);
    cycle(1, 1, 32'h0000_0100);
    cycle(1, 0, 32'h0);
    check("redir_flushed", obs_valid, 1'b0);
    check("redir_req", obs_req, 1'b1);
    check("redir_addr", obs_addr, 32'h100);
    cycle(1, 0, 32'h0);
    cycle(1, 0, 32'h0);
    check("redir_lat_valid", obs_valid, 1'b1);
    check("redir_lat_pc", obs_pc, 32'h100);

    // Redirect coinciding with a pop and a push.
    cycle(1, 1, 32'h0000_0200);
    check("rpp_head_was_valid", obs_valid, 1'b1);
    cycle(1, 0, 32'h0);
    check("rpp_empty", obs_valid, 1'b0);
    check("rpp_addr", obs_addr, 32'h200);

    // PC wrap.
    cycle(1, 0, 32'h0);
    cycle(1, 1, 32'hFFFF_FFFC);
    cycle(1, 0, 32'h0);
    check("wrap_addr0", obs_addr, 32'hFFFF_FFFC);
    cycle(1, 0, 32'h0);
    check("wrap_addr1", obs_addr, 32'h0);
    cycle(1, 0, 32'h0);
    check("wrap_pc", obs_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", obs_pc4, 32'h0);
    cycle(1, 0, 32'h0);
    check("wrap_next_pc", obs_pc, 32'h0);

`ifdef FETCH_MISALIGN_EXC_EN
    cycle(0, 1, 32'h0000_0102);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 32'h0);
      check("halt_req", obs_req, 1'b0);
      check("halt_pc", obs_pc, 32'h102);
      check("halt_inst", obs_inst, NOP);
    end
    cycle(1, 0, 32'h0);
    cycle(1, 0, 32'h0);
    check("halt_popped", obs_valid, 1'b0);
    check("halt_still_req", obs_req, 1'b0);
    cycle(1, 1, 32'h0000_0200);
    cycle(1, 0, 32'h0);
    check("halt_exit_req", obs_req, 1'b1);
    check("halt_exit_addr", obs_addr, 32'h200);
`else
    cycle(1, 1, 32'h0000_0102);
    cycle(1, 0, 32'h0);
    check("align_addr", obs_addr, 32'h100);
`endif

    // Reset in the middle of streaming.
    for (int k = 0; k < 3; k++) cycle(1, 0, 32'h0);
    do_reset();
    cycle(1, 0, 32'h0);
    check("post_rst_addr", obs_addr, RESET_PC);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      logic [31:0] tgt;
      tgt = $urandom() & 32'h0000_FFFC;
      if ($urandom_range(0, 9) == 0) tgt = tgt | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, tgt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
